multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel programmable timer: the next generation of the single-channel max/increment counter. It provides CHANNELS independent counters, each with its own limit, step and mode (one-shot or periodic), plus start/stop/pause control. It adds a shared prescaler strobe, expiry pulses and a configuration-conflict flag. It sits between game/control logic and the modules that need timed events, such as animation steps, timeouts and debounce windows.

## Interface
- WIDTH, 32, counter/limit width in bits
- CHANNELS, 4, number of independent channels (1..16)
- INCR_W, 8, width of the per-channel extra-step value
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- en  in  1  global count strobe; a counting step occurs only in cycles with en=1
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel of write
- cfg_max  in  WIDTH  limit
- cfg_incr  in  INCR_W  extra step; each step adds 1+cfg_incr
- cfg_mode  in  1  0 = one-shot, 1 = periodic
- start  in  CHANNELS  per-channel start pulse
- stop  in  CHANNELS  per-channel pause pulse
- clr  in  CHANNELS  per-channel acknowledge/clear
- busy  out  CHANNELS  channel in RUN
- done  out  CHANNELS  channel in EXPIRED (level)
- tick  out  CHANNELS  one-cycle expiry pulse
- cnt  out  CHANNELS*WIDTH  current counters, channel i at [i*WIDTH +: WIDTH]
- cfg_err  out  1  one-cycle pulse: write rejected

## Operation
- Per-channel registers: max, incr, mode, ctr, state ∈ {IDLE, RUN, PAUSE, EXPIRED}.
- Reset (rst=0, async): all registers 0, all states IDLE. Outputs busy, done, tick, cnt and cfg_err are all 0.
- Config write (cfg_we=1):
  - Accepted when the target state ≠ RUN. It loads max/incr/mode, sets ctr=0 and state=IDLE.
  - If the target is in RUN, the write is ignored and cfg_err=1 in the next cycle.
  - cfg_ch ≥ CHANNELS is ignored and also raises cfg_err.
- Control priority per channel, highest first: clr, stop, start.
  - clr: EXPIRED or PAUSE → IDLE, ctr=0. No effect in other states.
  - stop: RUN → PAUSE, ctr held. No effect in other states.
  - start: IDLE/EXPIRED → RUN with ctr=0; PAUSE → RUN with ctr kept. Ignored in RUN.
  - A config write to a channel in the same cycle as its control pulse: config applies first, then the control is evaluated on the new state. Write followed by start in one cycle gives RUN with ctr=0.
- Counting in RUN with en=1 and no stop/clr:
  - sum = ctr + 1 + incr, computed in WIDTH+1 bits (no wrap).
  - If sum < max: ctr ← sum.
  - If sum ≥ max (expiry): tick pulses. One-shot: ctr ← max and state ← EXPIRED. Periodic: ctr ← 0 and state stays RUN.
  - max=0: expiry on the first enabled step.
  - Number of enabled steps to expiry = max(1, ceil(max/(1+incr))).
- With en=0, or in any state other than RUN, ctr holds.
- Channels are fully independent: simultaneous expiries on several channels each give their own tick.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- start sampled at edge k: busy=1 after edge k. The first count step is at edge k+1 if en=1.
- Expiry decided at edge m: tick=1 for exactly the cycle after edge m. done (one-shot) rises after edge m, together with cnt=max.
- cfg_err is high for exactly one cycle, after the edge on which the rejected write was sampled.
- stop at edge p: busy=0 after edge p. No step is taken at edge p, even with en=1.
- Reset asserted mid-operation: all state is cleared immediately (async). The first counting step is possible only after a config and a start following reset deassertion.

## Test plan
- Ch0: one-shot, max=10, incr=0, en=1, start → tick after the 10th step, done=1, cnt0=10; done holds until clr, then cnt0=0 and done=0.
- Ch1: one-shot, max=10, incr=3 → cnt1 = 4, 8, then expiry on step 3 with cnt1 clamped to 10 and tick1 for 1 cycle.
- Ch2: periodic, max=4, incr=0, en=1 continuously → tick2 every 4 cycles, cnt2 cycles 1, 2, 3, 0, busy2 stays 1; with en toggling every other cycle, tick2 every 8 cycles.
- Ch3 running: cfg_we to ch3 → cfg_err one cycle, config unchanged. stop at cnt=5 → busy=0, cnt holds 5 across 20 cycles. start → continues from 5 to expire at max.
- max=0 one-shot → tick on the first enabled step. Simultaneous clr+stop+start on a PAUSE channel → IDLE, cnt=0.
- rst pulled low mid-count on all channels → all outputs 0 asynchronously, states IDLE after release, and no counting without a new start.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel programmable timer.
// Each channel owns a limit, an extra step and a one-shot/periodic mode, and
// runs an IDLE/RUN/PAUSE/EXPIRED control machine. A shared count strobe
// advances every running channel; expiries raise a one-cycle tick per channel.
// Configuration writes to a running (or non-existent) channel are rejected
// with a one-cycle cfg_err pulse.
module multi_timer #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int INCR_W   = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         cfg_we_i,
    input  logic [CH_W-1:0]              cfg_ch_i,
    input  logic [WIDTH-1:0]             cfg_max_i,
    input  logic [INCR_W-1:0]            cfg_incr_i,
    input  logic                         cfg_mode_i,
    input  logic [CHANNELS-1:0]          start_i,
    input  logic [CHANNELS-1:0]          stop_i,
    input  logic [CHANNELS-1:0]          clr_i,
    output logic [CHANNELS-1:0]          busy_o,
    output logic [CHANNELS-1:0]          done_o,
    output logic [CHANNELS-1:0]          tick_o,
    output logic [CHANNELS*WIDTH-1:0]    cnt_o,
    output logic                         cfg_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [WIDTH-1:0]    ctr_q   [CHANNELS];
    logic [WIDTH-1:0]    ctr_d   [CHANNELS];
    logic [WIDTH-1:0]    max_q   [CHANNELS];
    logic [WIDTH-1:0]    max_d   [CHANNELS];
    logic [INCR_W-1:0]   incr_q  [CHANNELS];
    logic [INCR_W-1:0]   incr_d  [CHANNELS];
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] mode_d;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] tick_d;
    logic                cfg_err_q;
    logic                cfg_err_d;

    // Post-configuration view of each channel: control pulses act on this.
    state_e              cst_s   [CHANNELS];
    logic [WIDTH-1:0]    cctr_s  [CHANNELS];
    logic [WIDTH:0]      sum_s   [CHANNELS];
    logic [CHANNELS-1:0] cfg_hit_s;
    logic [CHANNELS-1:0] cfg_load_s;
    logic                cfg_in_range_s;

    // One step advance, one bit wider than the counter so it never wraps.
    function automatic logic [WIDTH:0] step_sum(input logic [WIDTH-1:0] ctr,
                                                 input logic [INCR_W-1:0] incr);
        step_sum = {1'b0, ctr} + {{(WIDTH + 1 - INCR_W){1'b0}}, incr}
                 + {{WIDTH{1'b0}}, 1'b1};
    endfunction

    // Decode which channel a configuration write targets, and whether it exists.
    always_comb begin
        cfg_in_range_s = (32'(cfg_ch_i) < 32'(CHANNELS));
        for (int i = 0; i < CHANNELS; i++) begin
            cfg_hit_s[i]  = cfg_we_i && cfg_in_range_s && (cfg_ch_i == CH_W'(i));
            cfg_load_s[i] = cfg_hit_s[i] && (state_q[i] != ST_RUN);
        end
    end

    // Per-channel next state: config first, then clr > stop > start, then counting.
    always_comb begin
        cfg_err_d = cfg_we_i && !cfg_in_range_s;
        for (int i = 0; i < CHANNELS; i++) begin
            cfg_err_d  = cfg_err_d | (cfg_hit_s[i] & (state_q[i] == ST_RUN));
            max_d[i]   = cfg_load_s[i] ? cfg_max_i  : max_q[i];
            incr_d[i]  = cfg_load_s[i] ? cfg_incr_i : incr_q[i];
            mode_d[i]  = cfg_load_s[i] ? cfg_mode_i : mode_q[i];
            cst_s[i]   = cfg_load_s[i] ? ST_IDLE : state_q[i];
            cctr_s[i]  = cfg_load_s[i] ? {WIDTH{1'b0}} : ctr_q[i];
            sum_s[i]   = step_sum(ctr_q[i], incr_q[i]);
            state_d[i] = cst_s[i];
            ctr_d[i]   = cctr_s[i];
            tick_d[i]  = 1'b0;
            case (cst_s[i])
                ST_IDLE: begin
                    if (start_i[i] && !clr_i[i] && !stop_i[i]) begin
                        state_d[i] = ST_RUN;
                        ctr_d[i]   = {WIDTH{1'b0}};
                    end else begin
                        state_d[i] = cst_s[i];
                    end
                end
                ST_PAUSE: begin
                    if (clr_i[i]) begin
                        state_d[i] = ST_IDLE;
                        ctr_d[i]   = {WIDTH{1'b0}};
                    end else if (start_i[i] && !stop_i[i]) begin
                        state_d[i] = ST_RUN;
                    end else begin
                        state_d[i] = cst_s[i];
                    end
                end
                ST_EXPIRED: begin
                    if (clr_i[i]) begin
                        state_d[i] = ST_IDLE;
                        ctr_d[i]   = {WIDTH{1'b0}};
                    end else if (start_i[i] && !stop_i[i]) begin
                        state_d[i] = ST_RUN;
                        ctr_d[i]   = {WIDTH{1'b0}};
                    end else begin
                        state_d[i] = cst_s[i];
                    end
                end
                ST_RUN: begin
                    // clr has no effect in RUN but still suppresses the step.
                    if (clr_i[i]) begin
                        state_d[i] = cst_s[i];
                    end else if (stop_i[i]) begin
                        state_d[i] = ST_PAUSE;
                    end else if (en_i) begin
                        if (sum_s[i] < {1'b0, max_q[i]}) begin
                            ctr_d[i] = sum_s[i][WIDTH-1:0];
                        end else begin
                            tick_d[i] = 1'b1;
                            if (mode_q[i]) begin
                                ctr_d[i] = {WIDTH{1'b0}};
                            end else begin
                                ctr_d[i]   = max_q[i];
                                state_d[i] = ST_EXPIRED;
                            end
                        end
                    end else begin
                        ctr_d[i] = cctr_s[i];
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    ctr_d[i]   = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State, counter, configuration and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                ctr_q[i]   <= {WIDTH{1'b0}};
                max_q[i]   <= {WIDTH{1'b0}};
                incr_q[i]  <= {INCR_W{1'b0}};
            end
            mode_q    <= {CHANNELS{1'b0}};
            tick_q    <= {CHANNELS{1'b0}};
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                ctr_q[i]   <= ctr_d[i];
                max_q[i]   <= max_d[i];
                incr_q[i]  <= incr_d[i];
            end
            mode_q    <= mode_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Outputs are direct decodes of registers only.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            busy_o[i]                  = (state_q[i] == ST_RUN);
            done_o[i]                  = (state_q[i] == ST_EXPIRED);
            cnt_o[i*WIDTH +: WIDTH]    = ctr_q[i];
        end
        tick_o    = tick_q;
        cfg_err_o = cfg_err_q;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed stimulus, a behavioural
// per-channel model checked every cycle, and hand-computed literal checks.
module tb_multi_timer;

    localparam int W  = 32;
    localparam int CH = 4;
    localparam int IW = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              en = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = 2'd0;
    logic [W-1:0]      cfg_max = '0;
    logic [IW-1:0]     cfg_incr = '0;
    logic              cfg_mode = 1'b0;
    logic [CH-1:0]     start = '0, stop = '0, clr = '0;
    logic [CH-1:0]     busy, done, tick;
    logic [CH*W-1:0]   cnt;
    logic              cfg_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Behavioural model state
    int     m_st   [CH];
    longint m_ctr  [CH];
    longint m_max  [CH];
    longint m_incr [CH];
    bit     m_mode [CH];
    bit     m_tick [CH];
    bit     m_err;

    multi_timer #(.WIDTH(W), .CHANNELS(CH), .INCR_W(IW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en),
        .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_max_i(cfg_max),
        .cfg_incr_i(cfg_incr), .cfg_mode_i(cfg_mode),
        .start_i(start), .stop_i(stop), .clr_i(clr),
        .busy_o(busy), .done_o(done), .tick_o(tick),
        .cnt_o(cnt), .cfg_err_o(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_st[i] = M_IDLE; m_ctr[i] = 0; m_max[i] = 0;
            m_incr[i] = 0; m_mode[i] = 1'b0; m_tick[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Apply the timer's rules to the inputs sampled at this edge.
    task automatic model_step();
        longint s;
        int c;
        m_err = 1'b0;
        for (int i = 0; i < CH; i++) m_tick[i] = 1'b0;
        if (cfg_we) begin
            c = int'(cfg_ch);
            if (m_st[c] == M_RUN) m_err = 1'b1;
            else begin
                m_max[c] = cfg_max; m_incr[c] = cfg_incr; m_mode[c] = cfg_mode;
                m_ctr[c] = 0; m_st[c] = M_IDLE;
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (clr[i]) begin
                if (m_st[i] == M_DONE || m_st[i] == M_PAUSE) begin
                    m_st[i] = M_IDLE; m_ctr[i] = 0;
                end
            end else if (stop[i]) begin
                if (m_st[i] == M_RUN) m_st[i] = M_PAUSE;
            end else if (start[i] && m_st[i] != M_RUN) begin
                if (m_st[i] != M_PAUSE) m_ctr[i] = 0;
                m_st[i] = M_RUN;
            end else if (m_st[i] == M_RUN && en) begin
                s = m_ctr[i] + 1 + m_incr[i];
                if (s >= m_max[i]) begin
                    m_tick[i] = 1'b1;
                    if (m_mode[i]) m_ctr[i] = 0;
                    else begin m_ctr[i] = m_max[i]; m_st[i] = M_DONE; end
                end else m_ctr[i] = s;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: model follows the edge, pulses are dropped afterwards.
    task automatic cycle();
        @(posedge clk);
        if (rst_ni) model_step();
        #1;
        cfg_we = 1'b0; start = '0; stop = '0; clr = '0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cfg(input int ch, input longint mx, input int inc, input bit md);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_max = W'(mx);
        cfg_incr = IW'(inc); cfg_mode = md;
    endtask

    function automatic logic [63:0] cnt_of(input int ch);
        return 64'(cnt[ch*W +: W]);
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [CH-1:0]   eb, ed, et;
        logic [CH*W-1:0] ec;
        if (chk_on) begin
            for (int i = 0; i < CH; i++) begin
                eb[i] = (m_st[i] == M_RUN);
                ed[i] = (m_st[i] == M_DONE);
                et[i] = m_tick[i];
                ec[i*W +: W] = W'(m_ctr[i]);
            end
            n_tests += 5;
            if (busy !== eb) begin n_fail++; $display("FAIL model_busy: got %b, expected %b", busy, eb); end
            if (done !== ed) begin n_fail++; $display("FAIL model_done: got %b, expected %b", done, ed); end
            if (tick !== et) begin n_fail++; $display("FAIL model_tick: got %b, expected %b", tick, et); end
            if (cnt !== ec) begin n_fail++; $display("FAIL model_cnt: got %h, expected %h", cnt, ec); end
            if (cfg_err !== m_err) begin n_fail++; $display("FAIL model_cfg_err: got %b, expected %b", cfg_err, m_err); end
        end
    end

    initial begin
        int tcount;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_cnt_any", 64'(|cnt), 64'd0);
        chk("reset_err", 64'(cfg_err), 64'd0);
        chk_on = 1'b1;
        en = 1'b1;

        // Ch0 one-shot max=10, step 1
        cfg(0, 10, 0, 0); cycle();
        start = 4'b0001; cycle();
        chk("ch0_busy_start", 64'(busy[0]), 64'd1);
        chk("ch0_cnt_start", cnt_of(0), 64'd0);
        cycles(9);
        chk("ch0_cnt9", cnt_of(0), 64'd9);
        chk("ch0_notick9", 64'(tick[0]), 64'd0);
        cycle();
        chk("ch0_tick", 64'(tick[0]), 64'd1);
        chk("ch0_done", 64'(done[0]), 64'd1);
        chk("ch0_cnt_max", cnt_of(0), 64'd10);
        cycle();
        chk("ch0_tick_once", 64'(tick[0]), 64'd0);
        chk("ch0_done_hold", 64'(done[0]), 64'd1);
        clr = 4'b0001; cycle();
        chk("ch0_clr_done", 64'(done[0]), 64'd0);
        chk("ch0_clr_cnt", cnt_of(0), 64'd0);

        // Ch1 one-shot max=10, incr=3 -> 4, 8, clamp 10
        cfg(1, 10, 3, 0); cycle();
        start = 4'b0010; cycle();
        cycle(); chk("ch1_cnt4", cnt_of(1), 64'd4);
        cycle(); chk("ch1_cnt8", cnt_of(1), 64'd8);
        cycle();
        chk("ch1_cnt_clamp", cnt_of(1), 64'd10);
        chk("ch1_tick", 64'(tick[1]), 64'd1);

        // Ch2 periodic max=4
        cfg(2, 4, 0, 1); cycle();
        start = 4'b0100; cycle();
        cycles(3); chk("ch2_cnt3", cnt_of(2), 64'd3);
        cycle();
        chk("ch2_wrap_cnt", cnt_of(2), 64'd0);
        chk("ch2_wrap_tick", 64'(tick[2]), 64'd1);
        chk("ch2_busy", 64'(busy[2]), 64'd1);
        cycles(4); chk("ch2_tick_again", 64'(tick[2]), 64'd1);
        tcount = 0;
        for (int k = 0; k < 16; k++) begin
            en = (k % 2 == 0);
            cycle();
            if (tick[2]) tcount++;
        end
        chk("ch2_ticks_half_rate", 64'(tcount), 64'd2);
        en = 1'b1;

        // Ch3 rejected write, pause, resume
        cfg(3, 20, 0, 0); cycle();
        start = 4'b1000; cycle();
        cycles(5); chk("ch3_cnt5", cnt_of(3), 64'd5);
        en = 1'b0;
        cfg(3, 7, 2, 1); cycle();
        chk("ch3_cfg_err", 64'(cfg_err), 64'd1);
        chk("ch3_cnt_kept", cnt_of(3), 64'd5);
        cycle(); chk("ch3_cfg_err_once", 64'(cfg_err), 64'd0);
        stop = 4'b1000; cycle();
        chk("ch3_stop_busy", 64'(busy[3]), 64'd0);
        en = 1'b1;
        cycles(20); chk("ch3_paused_cnt", cnt_of(3), 64'd5);
        start = 4'b1000; cycle();
        chk("ch3_resume_cnt", cnt_of(3), 64'd5);
        cycles(14); chk("ch3_cnt19", cnt_of(3), 64'd19);
        cycle();
        chk("ch3_done", 64'(done[3]), 64'd1);
        chk("ch3_cnt20", cnt_of(3), 64'd20);

        // max=0 with write and start in the same cycle
        cfg(0, 0, 0, 0); start = 4'b0001; cycle();
        chk("max0_busy", 64'(busy[0]), 64'd1);
        cycle();
        chk("max0_tick", 64'(tick[0]), 64'd1);
        chk("max0_done", 64'(done[0]), 64'd1);

        // clr+stop+start on a paused channel
        cfg(1, 100, 0, 0); cycle();
        start = 4'b0010; cycle();
        cycles(3);
        stop = 4'b0010; cycle();
        chk("ch1_pause_cnt", cnt_of(1), 64'd3);
        clr = 4'b0010; stop = 4'b0010; start = 4'b0010; cycle();
        chk("ch1_prio_cnt", cnt_of(1), 64'd0);
        chk("ch1_prio_busy", 64'(busy[1]), 64'd0);

        // Async reset mid-count
        for (int i = 0; i < CH; i++) begin cfg(i, 1000, 1, 1); cycle(); end
        start = 4'b1111; cycle();
        cycles(5);
        @(posedge clk); model_step();
        #3 rst_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_async_cnt", 64'(|cnt), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        cycles(2);
        @(posedge clk); #2 rst_ni = 1'b1;
        cycles(5);
        chk("rst_no_count", 64'(|cnt), 64'd0);
        chk("rst_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
